tile_out_capture: RTL and testbench

TILE_OUT_CAPTURE -- requirements
Module: tile_out_capture

---
 rtl/tile_cap_pkg.sv | 17 +
 rtl/tile_cap_fifo.sv | 59 +++++
 rtl/tile_out_capture.sv | 96 +++++++++
 tb/tb_tile_out_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tile_cap_pkg.sv
// rtl/tile_cap_pkg.sv - shared capture FSM states and event record
package tile_cap_pkg;

  localparam int TS_W_PKG = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic [7:0]          data;
    logic [TS_W_PKG-1:0] ts;
  } cap_evt_t;

endpackage

// File: rtl/tile_cap_fifo.sv
// rtl/tile_cap_fifo.sv - first-word-fall-through event FIFO with occupancy and drop flag
module tile_cap_fifo
  import tile_cap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(cap_evt_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         full;
  logic         pop_ok;
  logic         push_ok;

  assign level   = wr_q - rd_q;
  assign valid   = (level != '0);
  assign full    = (level == FULL_LVL);
  assign pop_ok  = pop && valid;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign rdata   = valid ? mem_q[rd_q[AW-1:0]] : '0;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tile_out_capture.sv
// rtl/tile_out_capture.sv - timestamps changes on a microtile output bus into an event FIFO
module tile_out_capture
  import tile_cap_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = TS_W_PKG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             uo_in,
  input  logic                   enable,
  input  logic                   clear_ovf,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [7:0]             evt_data,
  output logic [TS_W-1:0]        evt_ts,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int EVT_W = 8 + TS_W;

  cap_state_e       state_q, state_d;
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       last_q, last_d;
  logic [TS_W-1:0]  ts_q;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             drop;
  logic [EVT_W-1:0] head;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRIME;
      end
      // Baseline the synchronized bus so re-enabling never reports stale changes.
      ST_PRIME: begin
        last_d  = sync2_q;
        state_d = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sync2_q != last_q) begin
          push   = 1'b1;
          last_d = sync2_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= uo_in;
      sync2_q <= sync1_q;
      last_q  <= last_d;
      ts_q    <= ts_q + 1'b1;
      ovf_q   <= ovf_d;
    end
  end

  tile_cap_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({sync2_q, ts_q}),
    .pop   (evt_ready),
    .rdata (head),
    .valid (evt_valid),
    .level (level),
    .drop  (drop)
  );

  assign evt_data = head[EVT_W-1:TS_W];
  assign evt_ts   = head[TS_W-1:0];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tile_out_capture.sv
// tb/tb_tile_out_capture.sv - scoreboard bench for tile_out_capture
module tb_tile_out_capture;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uo_in = '0;
  logic       enable = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [7:0] evt_ts;
  logic       overflow;
  logic [2:0] level;

  tile_out_capture #(.DEPTH(DEPTH), .TS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .uo_in     (uo_in),
    .enable    (enable),
    .clear_ovf (clear_ovf),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ts    (evt_ts),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit mon_on = 1'b0;

  // Reference: uo history as a plain delay line, enable as a run-length count
  logic [7:0]  m_s1, m_s2, m_last, m_ts;
  int          m_streak, m_lvl;
  bit          m_ovf;
  logic [15:0] exp_q [$];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] u, input bit en, input bit rdy,
                            input bit clr, input bit r);
    bit do_push;
    bit pop_now;
    bit set_ovf;
    do_push = 1'b0;
    set_ovf = 1'b0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_ts = '0;
      m_streak = 0; m_lvl = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      // two consecutive enabled edges prime the baseline; from the third on, changes count
      if (en && m_streak >= 2 && m_s2 != m_last) do_push = 1'b1;
      if (en && m_streak >= 1) m_last = m_s2;
      m_streak = en ? m_streak + 1 : 0;
      pop_now = rdy && (m_lvl > 0);
      if (do_push) begin
        if (m_lvl < DEPTH || pop_now) begin
          exp_q.push_back({m_s2, m_ts});
          m_lvl++;
        end else begin
          set_ovf = 1'b1;
        end
      end
      if (pop_now) m_lvl--;
      if (set_ovf) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_s2 = m_s1;
      m_s1 = u;
      m_ts = m_ts + 8'd1;
    end
  endtask

  task automatic cyc(input logic [7:0] u, input bit en, input bit rdy,
                     input bit clr, input bit r);
    uo_in = u; enable = en; evt_ready = rdy; clear_ovf = clr; rst = r;
    @(posedge clk);
    model_step(u, en, rdy, clr, r);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("evt_valid", int'(evt_valid), int'(m_lvl != 0));
      check("level", int'(level), m_lvl);
      check("overflow", int'(overflow), int'(m_ovf));
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          check("head_expected_present", 0, 1);
        end else begin
          check("evt_data", int'(evt_data), int'(exp_q[0][15:8]));
          check("evt_ts", int'(evt_ts), int'(exp_q[0][7:0]));
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    logic [7:0] v;
    cyc(8'h00, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 0, 1);
    mon_on = 1'b1;
    check("reset_evt_data", int'(evt_data), 0);
    check("reset_evt_ts", int'(evt_ts), 0);
    check("reset_evt_valid", int'(evt_valid), 0);

    for (int i = 0; i < 20; i++) cyc(8'h00, 1, 0, 0, 0);
    check("quiet_level", int'(level), 0);

    for (int i = 0; i < 4; i++) cyc(8'h5A, 1, 0, 0, 0);
    check("first_evt_data", int'(evt_data), 8'h5A);
    check("first_level", int'(level), 1);
    for (int i = 0; i < 2; i++) cyc(8'h5A, 1, 1, 0, 0);

    for (int c = 0; c < 5; c++)
      for (int i = 0; i < 3; i++) cyc(8'hA1 + 8'(c), 1, 0, 0, 0);
    cyc(8'hA5, 1, 0, 0, 0);
    check("ovf_level", int'(level), 4);
    check("ovf_flag", int'(overflow), 1);
    cyc(8'hA5, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(8'hA5, 1, 1, 0, 0);

    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++) cyc(8'hB1 + 8'(c), 1, 0, 0, 0);
    cyc(8'hB5, 1, 0, 0, 0);
    cyc(8'hB5, 1, 0, 0, 0);
    cyc(8'hB5, 1, 1, 0, 0);
    check("full_pushpop_level", int'(level), 4);
    check("full_pushpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 5; i++) cyc(8'hB5, 1, 1, 0, 0);

    for (int i = 0; i < 3; i++) cyc(8'h11, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(8'h11, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(8'h22, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(8'h22, 1, 0, 0, 0);
    check("reenable_no_event", int'(level), 0);
    for (int i = 0; i < 4; i++) cyc(8'h33, 1, 0, 0, 0);
    check("reenable_evt_data", int'(evt_data), 8'h33);
    cyc(8'h33, 1, 1, 0, 0);

    n = 0;
    while (m_ts != 8'hFD && n < 300) begin
      cyc(8'h33, 1, 0, 0, 0);
      n++;
    end
    check("ts_wrap_reached", int'(m_ts == 8'hFD), 1);
    cyc(8'hC1, 1, 0, 0, 0);
    cyc(8'hC2, 1, 0, 0, 0);
    cyc(8'hC2, 1, 0, 0, 0);
    cyc(8'hC2, 1, 0, 0, 0);
    check("wrap_head_ts", int'(evt_ts), 8'hFF);
    for (int i = 0; i < 3; i++) cyc(8'hC3, 1, 0, 0, 0);
    check("pre_reset_level", int'(level), 3);
    cyc(8'hC3, 1, 0, 0, 1);
    check("post_reset_valid", int'(evt_valid), 0);
    check("post_reset_level", int'(level), 0);

    v = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) v = 8'($urandom);
      cyc(v, $urandom_range(0, 15) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
